// File: rtl/bridge2xheep_pkg.sv
// ---------------------------------------------------------------------------
// bridge2xheep_pkg : shared types for the bridge-to-X-HEEP OBI arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bridge2xheep_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_e;

  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [OBI_ADDR_W-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  // Watchdog counter width for a given limit; TO_W in the top is derived here.
  function automatic int unsigned to_w(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bridge2xheep_rr_arb.sv
// ---------------------------------------------------------------------------
// bridge2xheep_rr_arb : 2-way round-robin arbiter, write favoured after reset. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bridge2xheep_rr_arb
  import bridge2xheep_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,    // [0] write, [1] read
  input  logic       advance_i,
  output logic [1:0] gnt_o,
  output req_id_e    ptr_o
);

  req_id_e ptr_q;
  req_id_e ptr_d;

  always_comb begin
    gnt_o = valid_i;
    if (valid_i == 2'b11) begin
      gnt_o = (ptr_q == REQ_WR) ? 2'b01 : 2'b10;
    end
  end

  // After any grant the pointer favours the requester that lost.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (valid_i != 2'b00)) begin
      ptr_d = gnt_o[0] ? REQ_RD : REQ_WR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= REQ_WR;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/bridge2xheep_obi_arb.sv
// ---------------------------------------------------------------------------
// bridge2xheep_obi_arb : schedules bridge write/read requests onto one OBI master
// port. Optional macro BRIDGE2XHEEP_OBI_TIMEOUT_EN adds a handshake watchdog. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bridge2xheep_obi_arb
  import bridge2xheep_pkg::*;
#(
  parameter int unsigned ADDR_W         = OBI_ADDR_W,
  parameter int unsigned DATA_W         = OBI_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_wdata,
  input  logic [3:0]        wr_be,
  output logic              wr_done,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              rd_rvalid,
  output logic              obi_req,
  input  logic              obi_gnt,
  output logic [ADDR_W-1:0] obi_addr,
  output logic              obi_we,
  output logic [3:0]        obi_be,
  output logic [DATA_W-1:0] obi_wdata,
  input  logic              obi_rvalid,
  input  logic [DATA_W-1:0] obi_rdata,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  state_e            state_q;
  obi_req_t          txn_q;
  obi_req_t          accept_txn;
  logic              wr_done_q;
  logic              rd_rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_rdata_q;
  logic [1:0]        arb_gnt;
  req_id_e           rr_ptr;
  logic              idle;
  logic              accept;
  logic              spurious;
  logic              to_abort;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cfg_check
    // A limit below 2 cannot cover a single handshake phase.
  end

  assign idle   = (state_q == IDLE);
  assign accept = idle && (wr_valid || rd_valid);

  bridge2xheep_rr_arb u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .valid_i   ({rd_valid, wr_valid}),
    .advance_i (idle),
    .gnt_o     (arb_gnt),
    .ptr_o     (rr_ptr)
  );

  assign wr_ready = idle && arb_gnt[0];
  assign rd_ready = idle && arb_gnt[1];

  always_comb begin
    accept_txn = '0;
    if (arb_gnt[0]) begin
      accept_txn.addr  = wr_addr;
      accept_txn.we    = 1'b1;
      accept_txn.be    = wr_be;
      accept_txn.wdata = wr_wdata;
    end else begin
      accept_txn.addr  = rd_addr;
      accept_txn.we    = 1'b0;
      accept_txn.be    = 4'hF;
      accept_txn.wdata = '0;
    end
  end

  assign spurious = obi_rvalid && (state_q != WAIT_R);

`ifdef BRIDGE2XHEEP_OBI_TIMEOUT_EN
  localparam int unsigned TO_W = to_w(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_hit;

  assign to_hit   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign to_abort = to_hit && (((state_q == REQ) && !obi_gnt) ||
                               ((state_q == WAIT_R) && !obi_rvalid));

  // Restarts on entry to each phase: IDLE->REQ from zero, REQ->WAIT_R on gnt.
  always_ff @(posedge clk) begin
    if (rst || idle || ((state_q == REQ) && obi_gnt)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      txn_q       <= '0;
      wr_done_q   <= 1'b0;
      rd_rvalid_q <= 1'b0;
      rd_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_done_q   <= 1'b0;
      rd_rvalid_q <= 1'b0;
      if (spurious || to_abort) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            txn_q   <= accept_txn;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (obi_gnt) begin
            state_q <= WAIT_R;
          end else if (to_abort) begin
            state_q <= IDLE;
          end
        end
        WAIT_R: begin
          if (obi_rvalid) begin
            // The pointer names the requester that did not win the access in flight.
            if (rr_ptr == REQ_WR) begin
              rd_rdata_q  <= obi_rdata;
              rd_rvalid_q <= 1'b1;
            end else begin
              wr_done_q   <= 1'b1;
            end
            state_q <= IDLE;
          end else if (to_abort) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign obi_req   = (state_q == REQ);
  assign obi_addr  = txn_q.addr;
  assign obi_we    = txn_q.we;
  assign obi_be    = txn_q.be;
  assign obi_wdata = txn_q.wdata;
  assign busy      = !idle;
  assign err       = err_q;
  assign wr_done   = wr_done_q;
  assign rd_rvalid = rd_rvalid_q;
  assign rd_rdata  = rd_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_bridge2xheep_obi_arb.sv
// ---------------------------------------------------------------------------
// tb_bridge2xheep_obi_arb : randomized transaction-level bench for the OBI arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bridge2xheep_obi_arb;

`ifdef BRIDGE2XHEEP_OBI_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0, rd_valid = 1'b0;
  logic        wr_ready, rd_ready, wr_done, rd_rvalid;
  logic [31:0] wr_addr = '0, wr_wdata = '0, rd_addr = '0, rd_rdata;
  logic [3:0]  wr_be = '0;
  logic        obi_req, obi_we, busy, err;
  logic        obi_gnt = 1'b0, obi_rvalid = 1'b0, err_clr = 1'b0;
  logic [31:0] obi_addr, obi_wdata, obi_rdata = '0;
  logic [3:0]  obi_be;

  bridge2xheep_obi_arb #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_wdata(wr_wdata),
    .wr_be(wr_be), .wr_done(wr_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_rdata(rd_rdata),
    .rd_rvalid(rd_rvalid),
    .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr), .obi_we(obi_we),
    .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_rvalid(obi_rvalid), .obi_rdata(obi_rdata),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: pending requests per side, fairness memory, expected access.
  logic        pw = 1'b0, pr = 1'b0;
  logic [31:0] pw_addr = '0, pw_data = '0, pr_addr = '0;
  logic [3:0]  pw_be = '0;
  logic        last_rd = 1'b1;
  logic [31:0] e_addr = '0, e_wdata = '0, m_rdata = '0;
  logic [3:0]  e_be = '0;
  logic        e_we = 1'b0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    last_rd = 1'b1;
    m_rdata = '0;
  endtask

  task automatic arm_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    pw = 1'b1; pw_addr = a; pw_data = d; pw_be = be;
  endtask

  task automatic arm_rd(input logic [31:0] a);
    pr = 1'b1; pr_addr = a;
  endtask

  task automatic arm_wr_rand();
    arm_wr($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(1, 15)));
  endtask

  task automatic arm_rd_rand();
    arm_rd($urandom & 32'hFFFF_FFFC);
  endtask

  task automatic drive_reqs();
    wr_valid = pw; wr_addr = pw_addr; wr_wdata = pw_data; wr_be = pw_be;
    rd_valid = pr; rd_addr = pr_addr;
  endtask

  // Called at a negedge with the DUT idle and at least one request pending.
  task automatic do_accept();
    logic win_wr;
    drive_reqs();
    #1;
    win_wr = pw && (!pr || last_rd);
    chk("wr_ready", wr_ready, win_wr);
    chk("rd_ready", rd_ready, !win_wr);
    chk("busy_idle", busy, 0);
    if (win_wr) begin
      e_addr = pw_addr; e_we = 1'b1; e_be = pw_be; e_wdata = pw_data; pw = 1'b0;
    end else begin
      e_addr = pr_addr; e_we = 1'b0; e_be = 4'hF; e_wdata = '0; pr = 1'b0;
    end
    last_rd = !win_wr;
    tick();
  endtask

  // OBI slave: grant after gd stall cycles, respond rdl cycles after the grant.
  task automatic serve(input int gd, input int rdl, input logic [31:0] rdata);
    drive_reqs();
    for (int i = 0; i <= gd; i++) begin
      #1;
      chk("obi_req", obi_req, 1);
      chk("obi_addr", obi_addr, e_addr);
      chk("obi_we", obi_we, e_we);
      chk("obi_be", obi_be, e_be);
      chk("obi_wdata", obi_wdata, e_wdata);
      chk("busy_req", busy, 1);
      chk("ready_busy", {wr_ready, rd_ready}, 0);
      obi_gnt = (i == gd);
      tick();
    end
    obi_gnt = 1'b0;
    for (int j = 0; j <= rdl; j++) begin
      chk("req_drop", obi_req, 0);
      chk("addr_hold", obi_addr, e_addr);
      chk("busy_wait", busy, 1);
      chk("no_pulse", {wr_done, rd_rvalid}, 0);
      obi_rvalid = (j == rdl);
      obi_rdata  = rdata;
      tick();
    end
    obi_rvalid = 1'b0;
    obi_rdata  = $urandom;
    if (!e_we) m_rdata = rdata;
    chk("wr_done", wr_done, e_we);
    chk("rd_rvalid", rd_rvalid, !e_we);
    chk("rd_rdata", rd_rdata, m_rdata);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_obi_req", obi_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_pulses", {wr_done, rd_rvalid}, 0);
    chk("rst_rd_rdata", rd_rdata, 0);
    chk("rst_obi_addr", obi_addr, 0);
    chk("rst_ready", {wr_ready, rd_ready}, 0);

    // Single best-case write
    arm_wr(32'h0000_0180, 32'hDEAD_BEEF, 4'hF);
    do_accept();
    serve(0, 0, $urandom);

    // Single read with a 3-cycle grant stall
    arm_rd(32'h0000_0200);
    do_accept();
    serve(3, 0, 32'h1234_5678);

    // Both requesters held valid: grants must alternate W,R,W,R
    arm_wr_rand();
    arm_rd_rand();
    for (int k = 0; k < 4; k++) begin
      do_accept();
      if (!pw) arm_wr_rand();
      if (!pr) arm_rd_rand();
      serve($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end
    for (int k = 0; k < 2; k++) begin
      do_accept();
      serve($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    // Spurious rvalid, clear, then set colliding with clear
    drive_reqs();
    obi_rvalid = 1'b1; tick(); obi_rvalid = 1'b0;
    chk("spur_err_set", err, 1);
    chk("spur_busy", busy, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_cleared", err, 0);
    obi_rvalid = 1'b1; err_clr = 1'b1; tick(); obi_rvalid = 1'b0; err_clr = 1'b0;
    chk("set_beats_clr", err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_cleared2", err, 0);

    // Grant never arrives
    arm_wr_rand();
    do_accept();
    drive_reqs();
`ifdef BRIDGE2XHEEP_OBI_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      chk("to_req_high", obi_req, 1);
      tick();
    end
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_req_low", obi_req, 0);
    chk("to_no_done", wr_done, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to_err_clr", err, 0);
    chk("to_no_done2", wr_done, 0);
    obi_rvalid = 1'b1; tick(); obi_rvalid = 1'b0;
    chk("late_rvalid_err", err, 1);
    chk("late_no_done", wr_done, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
`else
    repeat (100) tick();
    chk("no_to_req_high", obi_req, 1);
    chk("no_to_err", err, 0);
    serve(0, 0, $urandom);
`endif

    // Reset during WAIT_R aborts the read and clears err
    obi_rvalid = 1'b1; tick(); obi_rvalid = 1'b0;
    chk("pre_rst_err", err, 1);
    arm_rd_rand();
    do_accept();
    drive_reqs();
    obi_gnt = 1'b1; tick(); obi_gnt = 1'b0;
    chk("wait_busy", busy, 1);
    rst = 1'b1; tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req", obi_req, 0);
    chk("mid_rst_err", err, 0);
    rst = 1'b0;
    model_reset();
    obi_rvalid = 1'b1; tick(); obi_rvalid = 1'b0;
    chk("post_rst_spur", err, 1);
    chk("post_rst_no_rv", rd_rvalid, 0);
    chk("post_rst_rdata", rd_rdata, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      if (!pw && $urandom_range(0, 1) == 1) arm_wr_rand();
      if (!pr && $urandom_range(0, 1) == 1) arm_rd_rand();
      if (!pw && !pr) begin
        if ($urandom_range(0, 1) == 1) arm_wr_rand();
        else arm_rd_rand();
      end
      do_accept();
      serve($urandom_range(0, 4), $urandom_range(0, 3), $urandom);
    end
    chk("final_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
